// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding, IR opcodes, DR selection and the
// 1149.1 next-state function.
package jtag_pkg;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET,
    RUN_TEST_IDLE,
    SELECT_DR_SCAN,
    CAPTURE_DR,
    SHIFT_DR,
    EXIT1_DR,
    PAUSE_DR,
    EXIT2_DR,
    UPDATE_DR,
    SELECT_IR_SCAN,
    CAPTURE_IR,
    SHIFT_IR,
    EXIT1_IR,
    PAUSE_IR,
    EXIT2_IR,
    UPDATE_IR
  } tap_state_e;

  typedef enum logic [1:0] {
    DR_IDCODE,
    DR_BYPASS,
    DR_EXT
  } dr_sel_e;

  localparam logic [4:0] IR_IDCODE = 5'h01;
  localparam logic [4:0] IR_DTMCS  = 5'h10;
  localparam logic [4:0] IR_DMI    = 5'h11;
  localparam logic [4:0] IR_BYPASS = 5'h1f;

  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    tap_state_e n;
    n = s;
    unique case (s)
      TEST_LOGIC_RESET: n = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    n = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   n = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
      CAPTURE_DR:       n = tms ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         n = tms ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         n = tms ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         n = tms ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         n = tms ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        n = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   n = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       n = tms ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         n = tms ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         n = tms ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         n = tms ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         n = tms ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        n = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      default:          n = TEST_LOGIC_RESET;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_sync.sv
// Multi-flop synchronizer for one JTAG pin, with single-cycle rise/fall
// strobes derived from the synchronized level.
module jtag_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  always_comb begin
    q    = chain[STAGES-1];
    rise = chain[STAGES-1] & ~prev;
    fall = ~chain[STAGES-1] & prev;
  end

endmodule

// File: rtl/jtag_tap.sv
// IEEE 1149.1 TAP controller clocked by the system clock: oversampled pins,
// 16-state FSM, IR, IDCODE/BYPASS registers and a shift port for the DTM.
module jtag_tap
  import jtag_pkg::*;
#(
  parameter int unsigned IR_WIDTH    = 5,
  parameter logic [31:0] IDCODE      = 32'h1000_0001,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tck,
  input  logic                tms,
  input  logic                tdi,
  input  logic                n_trst,
  output logic                tdo,
  output logic                tdo_oe,
  output logic [IR_WIDTH-1:0] ir,
  output logic                dr_capture,
  output logic                dr_shift,
  output logic                dr_update,
  output logic                dr_tdi,
  input  logic                dr_tdo
);

  localparam logic [IR_WIDTH-1:0] IR_RESET = IR_WIDTH'(IR_IDCODE);

  logic       tck_rise, tck_fall;
  logic       tms_q, tdi_q, trst_q;
  logic [6:0] sync_unused;

  jtag_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_tck (
    .clk(clk), .rst(rst), .d(tck),
    .q(sync_unused[0]), .rise(tck_rise), .fall(tck_fall)
  );
  jtag_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_tms (
    .clk(clk), .rst(rst), .d(tms),
    .q(tms_q), .rise(sync_unused[1]), .fall(sync_unused[2])
  );
  jtag_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_tdi (
    .clk(clk), .rst(rst), .d(tdi),
    .q(tdi_q), .rise(sync_unused[3]), .fall(sync_unused[4])
  );
  jtag_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_trst (
    .clk(clk), .rst(rst), .d(n_trst),
    .q(trst_q), .rise(sync_unused[5]), .fall(sync_unused[6])
  );

  tap_state_e          state;
  logic [IR_WIDTH-1:0] ir_shift;
  logic [31:0]         idcode_reg;
  logic                bypass_reg;
  dr_sel_e             dr_sel;
  logic                dr_lsb;

  always_comb begin
    dr_sel = DR_EXT;
    if (ir == IR_RESET)             dr_sel = DR_IDCODE;
    else if (ir == '1 || ir == '0)  dr_sel = DR_BYPASS;
  end

  always_comb begin
    dr_lsb = dr_tdo;
    unique case (dr_sel)
      DR_IDCODE: dr_lsb = idcode_reg[0];
      DR_BYPASS: dr_lsb = bypass_reg;
      default:   dr_lsb = dr_tdo;
    endcase
  end

  // Rise-edge work keys off the state before the transition; fall-edge work
  // sees the state the preceding rise just entered.
  always_ff @(posedge clk) begin
    if (rst || !trst_q) begin
      state      <= TEST_LOGIC_RESET;
      ir         <= IR_RESET;
      ir_shift   <= IR_RESET;
      idcode_reg <= IDCODE;
      bypass_reg <= 1'b0;
      tdo        <= 1'b0;
      tdo_oe     <= 1'b0;
      dr_capture <= 1'b0;
      dr_shift   <= 1'b0;
      dr_update  <= 1'b0;
      dr_tdi     <= 1'b0;
    end else begin
      dr_capture <= 1'b0;
      dr_shift   <= 1'b0;
      dr_update  <= 1'b0;

      if (state == TEST_LOGIC_RESET) begin
        ir       <= IR_RESET;
        ir_shift <= IR_RESET;
      end

      if (tck_rise) begin
        state <= tap_next(state, tms_q);
        unique case (state)
          CAPTURE_IR: ir_shift <= IR_WIDTH'(1);
          SHIFT_IR:   ir_shift <= {tdi_q, ir_shift[IR_WIDTH-1:1]};
          CAPTURE_DR: begin
            idcode_reg <= IDCODE;
            bypass_reg <= 1'b0;
            dr_capture <= (dr_sel == DR_EXT);
          end
          SHIFT_DR: begin
            unique case (dr_sel)
              DR_IDCODE: idcode_reg <= {tdi_q, idcode_reg[31:1]};
              DR_BYPASS: bypass_reg <= tdi_q;
              default: begin
                dr_shift <= 1'b1;
                dr_tdi   <= tdi_q;
              end
            endcase
          end
          default: ;
        endcase
      end

      if (tck_fall) begin
        tdo_oe <= (state == SHIFT_IR) || (state == SHIFT_DR);
        if (state == UPDATE_IR) ir <= ir_shift;
        if (state == UPDATE_DR && dr_sel == DR_EXT) dr_update <= 1'b1;
        if (state == SHIFT_IR)      tdo <= ir_shift[0];
        else if (state == SHIFT_DR) tdo <= dr_lsb;
      end
    end
  end

endmodule

// File: tb/tb_jtag_tap.sv
// Directed bench for jtag_tap: reset, IDCODE read, IR load, external/bypass
// DR scans, and abort of a DR scan by tms and by n_trst.
module tb_jtag_tap;
  import jtag_pkg::*;

  logic       clk = 1'b0;
  logic       rst, tck, tms, tdi, n_trst, dr_tdo;
  logic       tdo, tdo_oe, dr_capture, dr_shift, dr_update, dr_tdi;
  logic [4:0] ir;

  int compared   = 0;
  int mismatched = 0;
  int cap_cnt = 0, shift_cnt = 0, upd_cnt = 0, overlap_cnt = 0;
  logic [63:0] mon_tdi = '0;

  always #5 clk = ~clk;

  jtag_tap #(.IR_WIDTH(5), .IDCODE(32'h1000_0001), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .tck(tck), .tms(tms), .tdi(tdi), .n_trst(n_trst),
    .tdo(tdo), .tdo_oe(tdo_oe), .ir(ir),
    .dr_capture(dr_capture), .dr_shift(dr_shift), .dr_update(dr_update),
    .dr_tdi(dr_tdi), .dr_tdo(dr_tdo)
  );

  always @(negedge clk) begin
    if (dr_capture) cap_cnt++;
    if (dr_shift) begin
      shift_cnt++;
      mon_tdi = {dr_tdi, mon_tdi[63:1]};
    end
    if (dr_update) upd_cnt++;
    if ((int'(dr_capture) + int'(dr_shift) + int'(dr_update) > 1) ||
        (rst === 1'b1 && (dr_capture | dr_shift | dr_update)))
      overlap_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rise_half(input logic m, input logic d);
    tms = m;
    tdi = d;
    repeat (3) @(negedge clk);
    tck = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic fall_half();
    tck = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic clock(input logic m, input logic d);
    rise_half(m, d);
    fall_half();
  endtask

  // From RUN_TEST_IDLE back to RUN_TEST_IDLE; checks ir holds until the UPDATE_IR fall.
  task automatic ir_scan(input logic [4:0] val, input logic [4:0] prev, output logic [4:0] out);
    clock(1'b1, 1'b0);
    clock(1'b1, 1'b0);
    clock(1'b0, 1'b0);
    clock(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      out[i] = tdo;
      clock(i == 4, val[i]);
    end
    rise_half(1'b1, 1'b0);
    check("ir_hold_before_update", 64'(ir), 64'(prev));
    fall_half();
    check("ir_after_update", 64'(ir), 64'(val));
    clock(1'b0, 1'b0);
  endtask

  // From RUN_TEST_IDLE back to RUN_TEST_IDLE; dout[0] is tdo on entering SHIFT_DR.
  task automatic dr_scan(input int n, input logic [63:0] din, input logic [63:0] ext,
                         output logic [63:0] dout, output logic oe_ok, output logic oe_exit);
    dout  = '0;
    oe_ok = 1'b1;
    clock(1'b1, 1'b0);
    clock(1'b0, 1'b0);
    dr_tdo = ext[0];
    clock(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      dout[i] = tdo;
      if (tdo_oe !== 1'b1) oe_ok = 1'b0;
      if (i < n - 1) dr_tdo = ext[i+1];
      clock(i == n - 1, din[i]);
    end
    oe_exit = tdo_oe;
    clock(1'b1, 1'b0);
    clock(1'b0, 1'b0);
  endtask

  logic [63:0] dout;
  logic [4:0]  irout;
  logic        oe_ok, oe_exit;
  int          c0, s0, u0, k;
  logic [63:0] ext_pat = 64'h0000_01A5_C3F0_9E71;
  logic [63:0] tdi_pat = 64'h0000_0135_7924_68AC;

  initial begin
    rst = 1'b1; tck = 1'b0; tms = 1'b1; tdi = 1'b0; n_trst = 1'b1; dr_tdo = 1'b0;

    // 1: reset, then tck toggles with tms=1
    @(negedge clk);
    check("rst_state", 64'(dut.state), 64'(TEST_LOGIC_RESET));
    check("rst_ir", 64'(ir), 64'h01);
    check("rst_tdo_oe", 64'(tdo_oe), 64'h0);
    check("rst_tdo", 64'(tdo), 64'h0);
    rst = 1'b0;
    repeat (5) clock(1'b1, 1'b0);
    check("tlr_hold_state", 64'(dut.state), 64'(TEST_LOGIC_RESET));
    check("tlr_no_dr_pulses", 64'(cap_cnt + shift_cnt + upd_cnt), 64'h0);
    check("tlr_tdo_oe", 64'(tdo_oe), 64'h0);

    // 2: IDCODE read
    clock(1'b0, 1'b0);
    check("rti_state", 64'(dut.state), 64'(RUN_TEST_IDLE));
    dr_scan(32, 64'h0, 64'h0, dout, oe_ok, oe_exit);
    check("idcode_tdo", dout, 64'h1000_0001);
    check("idcode_oe_shift", 64'(oe_ok), 64'h1);
    check("idcode_oe_exit", 64'(oe_exit), 64'h0);
    check("idcode_no_dr_pulses", 64'(cap_cnt + shift_cnt + upd_cnt), 64'h0);

    // 3: load IR_DMI
    ir_scan(IR_DMI, 5'h01, irout);
    check("ir_capture_tdo", 64'(irout), 64'h01);

    // 4: 41-bit external DR scan
    c0 = cap_cnt; s0 = shift_cnt; u0 = upd_cnt;
    dr_scan(41, tdi_pat, ext_pat, dout, oe_ok, oe_exit);
    check("ext_tdo_mirror", dout, ext_pat);
    check("ext_capture_cnt", 64'(cap_cnt - c0), 64'd1);
    check("ext_shift_cnt", 64'(shift_cnt - s0), 64'd41);
    check("ext_update_cnt", 64'(upd_cnt - u0), 64'd1);
    check("ext_dr_tdi", mon_tdi >> 23, tdi_pat);
    check("ext_oe_shift", 64'(oe_ok), 64'h1);

    // 5: bypass
    ir_scan(IR_BYPASS, IR_DMI, irout);
    c0 = cap_cnt; s0 = shift_cnt; u0 = upd_cnt;
    dr_scan(9, 64'hA5, 64'h0, dout, oe_ok, oe_exit);
    check("bypass_tdo", dout, 64'h14A);
    check("bypass_no_dr_pulses", 64'(cap_cnt + shift_cnt + upd_cnt - c0 - s0 - u0), 64'h0);

    // 6a: abandon an external scan with five tms=1 clocks
    ir_scan(IR_DTMCS, IR_BYPASS, irout);
    clock(1'b1, 1'b0);
    clock(1'b0, 1'b0);
    clock(1'b0, 1'b0);
    clock(1'b0, 1'b1);
    clock(1'b0, 1'b0);
    check("abort_tms_in_shift", 64'(dut.state), 64'(SHIFT_DR));
    repeat (5) clock(1'b1, 1'b0);
    check("abort_tms_state", 64'(dut.state), 64'(TEST_LOGIC_RESET));
    check("abort_tms_ir", 64'(ir), 64'h01);
    check("abort_tms_tdo_oe", 64'(tdo_oe), 64'h0);

    // 6b: abandon an external scan with n_trst
    clock(1'b0, 1'b0);
    ir_scan(IR_DMI, 5'h01, irout);
    clock(1'b1, 1'b0);
    clock(1'b0, 1'b0);
    clock(1'b0, 1'b0);
    clock(1'b0, 1'b1);
    check("abort_trst_in_shift", 64'(dut.state), 64'(SHIFT_DR));
    check("abort_trst_oe_before", 64'(tdo_oe), 64'h1);
    u0 = upd_cnt;
    n_trst = 1'b0;
    k = 0;
    while (dut.state != TEST_LOGIC_RESET && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("trst_latency_ok", 64'(k <= 3), 64'h1);
    check("trst_ir", 64'(ir), 64'h01);
    check("trst_tdo_oe", 64'(tdo_oe), 64'h0);
    n_trst = 1'b1;
    repeat (8) @(negedge clk);
    check("trst_no_update", 64'(upd_cnt - u0), 64'h0);
    check("trst_state_after", 64'(dut.state), 64'(TEST_LOGIC_RESET));

    check("dr_pulse_exclusive", 64'(overlap_cnt), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
